// File: rtl/types_pkg.sv
// Shared types and constants for the instruction fetch unit.
package types_pkg;

    typedef logic [31:0] DATA_BUS;

    // One fetched instruction together with its address and fall-through address.
    typedef struct packed {
        DATA_BUS pc;
        DATA_BUS instr;
        DATA_BUS pc_plus4;
    } FETCH_ENTRY;

    localparam int unsigned INSTR_BYTES = 32'd4;

    // Force a fetch target onto a word boundary.
    function automatic DATA_BUS align_word(input DATA_BUS addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Build a queue entry; the fall-through address wraps modulo 2^32.
    function automatic FETCH_ENTRY make_entry(input DATA_BUS pc, input DATA_BUS instr);
        FETCH_ENTRY e;
        e.pc       = pc;
        e.instr    = instr;
        e.pc_plus4 = pc + DATA_BUS'(INSTR_BYTES);
        return e;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// Circular FIFO of fetched entries with push, pop, flush and occupancy count.
// Flush wins over a push or pop in the same cycle.
module fetch_queue
    import types_pkg::*;
#(
    parameter  int QDEPTH = 4,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  FETCH_ENTRY    push_data,
    input  logic          pop,
    input  logic          flush,
    output FETCH_ENTRY    head,
    output logic [CW-1:0] count,
    output logic          not_empty
);

    FETCH_ENTRY    mem_r [QDEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          not_empty_r;

    logic          push_ok_s;
    logic          pop_ok_s;
    logic [CW-1:0] count_nxt_s;

    // Qualify push/pop against flush and emptiness, and work out the next count.
    always_comb begin
        push_ok_s   = push & ~flush;
        pop_ok_s    = pop & not_empty_r & ~flush;
        count_nxt_s = count_r;
        if (flush) begin
            count_nxt_s = {CW{1'b0}};
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_nxt_s = count_r + CW'(1'b1);
                2'b01:   count_nxt_s = count_r - CW'(1'b1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, count and the registered not-empty flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            not_empty_r <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1'b1);
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1'b1);
                end
            end
            count_r     <= count_nxt_s;
            not_empty_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign not_empty = not_empty_r;

endmodule

// File: rtl/instr_fetch_unit_rom.sv
// Instruction ROM with a registered read port. Word i of the image holds the
// value i, so fetched data directly identifies the word that was read.
module instr_rom
    import types_pkg::*;
#(
    parameter int ROM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ROM_AW-1:0] rd_idx,
    output DATA_BUS           rd_data
);

    DATA_BUS rd_data_r;

    // ROM image lookup.
    function automatic DATA_BUS rom_word(input logic [ROM_AW-1:0] idx);
        return DATA_BUS'(idx);
    endfunction

    // Registered read: the word appears the cycle after the address; held when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_r <= 32'h0000_0000;
        end else if (rd_en) begin
            rd_data_r <= rom_word(rd_idx);
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, registered ROM read,
// credit-limited fetch queue, and redirect handling with flush of stale work.
module instr_fetch_unit
    import types_pkg::*;
#(
    parameter DATA_BUS RESET_PC = 32'h0000_0000,
    parameter int      ROM_AW   = 12,
    parameter int      QDEPTH   = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    redirect_en,
    input  DATA_BUS redirect_addr,
    input  logic    out_ready,
    output logic    out_valid,
    output DATA_BUS out_instr,
    output DATA_BUS out_pc,
    output DATA_BUS out_pc_plus4,
    output DATA_BUS fetch_pc,
    output logic    misalign_err
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int OW = CW + 1;

    DATA_BUS       fetch_pc_r;
    logic          inflight_r;
    DATA_BUS       inflight_pc_r;
    logic          misalign_r;

    logic          issue_s;
    logic          push_s;
    logic          pop_s;
    logic [OW-1:0] occupancy_s;
    logic [CW-1:0] count_s;
    logic          not_empty_s;
    FETCH_ENTRY    head_s;
    FETCH_ENTRY    push_entry_s;
    DATA_BUS       rom_data_s;

    // Issue a read only when every outstanding word is guaranteed a queue slot,
    // so a returning word can never find the queue full.
    always_comb begin
        occupancy_s = OW'(count_s) + OW'(inflight_r);
        if (redirect_en) begin
            issue_s = 1'b0;
        end else if (occupancy_s < OW'(QDEPTH)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // A redirect kills the returning word and discards any simultaneous pop.
    always_comb begin
        push_s       = inflight_r & ~redirect_en;
        pop_s        = not_empty_s & out_ready & ~redirect_en;
        push_entry_s = make_entry(inflight_pc_r, rom_data_s);
    end

    // Fetch PC: load aligned redirect target, otherwise advance on each issued read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_en) begin
            fetch_pc_r <= align_word(redirect_addr);
        end else if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + DATA_BUS'(INSTR_BYTES);
        end
    end

    // In-flight tracking: the ROM word registered this cycle belongs to inflight_pc_r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_r;
            end
        end
    end

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_r <= 1'b0;
        end else if (redirect_en && (redirect_addr[1:0] != 2'b00)) begin
            misalign_r <= 1'b1;
        end
    end

    instr_rom #(
        .ROM_AW (ROM_AW)
    ) u_rom (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (issue_s),
        .rd_idx  (fetch_pc_r[ROM_AW+1:2]),
        .rd_data (rom_data_s)
    );

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_en),
        .head      (head_s),
        .count     (count_s),
        .not_empty (not_empty_s)
    );

    assign out_valid    = not_empty_s;
    assign out_instr    = head_s.instr;
    assign out_pc       = head_s.pc;
    assign out_pc_plus4 = head_s.pc_plus4;
    assign fetch_pc     = fetch_pc_r;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level reference model feeding a
// scoreboard, plus directed latency/boundary checks and randomized traffic.
module tb_instr_fetch_unit;
    import types_pkg::*;

    localparam int          QD  = 4;
    localparam int          AW  = 12;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    redirect_en = 1'b0;
    DATA_BUS redirect_addr = 32'h0;
    logic    out_ready = 1'b0;
    logic    out_valid;
    DATA_BUS out_instr, out_pc, out_pc_plus4, fetch_pc;
    logic    misalign_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC), .ROM_AW(AW), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .out_ready(out_ready), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .fetch_pc(fetch_pc),
        .misalign_err(misalign_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] fpc;
        logic        mis;
    } status_t;

    status_t     exp_status[$];
    logic [31:0] exp_txn[$];
    status_t     mon_s;
    logic [31:0] mon_pc;

    // Reference model: delivered pcs, outstanding reads with their arrival cycle.
    logic [31:0] m_q[$];
    logic [31:0] m_pend_pc[$];
    int          m_pend_due[$];
    logic [31:0] m_fpc;
    logic        m_mis;
    int          cyc;

    function automatic logic [31:0] rom_of(input logic [31:0] pc);
        return (pc >> 2) & ((32'd1 << AW) - 32'd1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend_pc.delete();
        m_pend_due.delete();
        m_fpc = RPC;
        m_mis = 1'b0;
        cyc   = 0;
    endtask

    // Drive this cycle's inputs, record what the DUT must show, advance the model.
    task automatic apply(input logic r, input logic [31:0] a, input logic rdy);
        status_t s;
        int      occ;
        logic [31:0] p;
        redirect_en   = r;
        redirect_addr = a;
        out_ready     = rdy;
        s.valid = (m_q.size() > 0);
        s.pc    = s.valid ? m_q[0] : 32'h0;
        s.fpc   = m_fpc;
        s.mis   = m_mis;
        exp_status.push_back(s);
        if (s.valid && rdy && !r) exp_txn.push_back(m_q[0]);
        occ = m_q.size() + m_pend_pc.size();
        if (r) begin
            m_q.delete();
            m_pend_pc.delete();
            m_pend_due.delete();
            m_fpc = {a[31:2], 2'b00};
            if (a[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            while (m_pend_due.size() > 0 && m_pend_due[0] == cyc) begin
                p = m_pend_pc.pop_front();
                void'(m_pend_due.pop_front());
                m_q.push_back(p);
            end
            if (occ < QD) begin
                m_pend_pc.push_back(m_fpc);
                m_pend_due.push_back(cyc + 1);
                m_fpc = m_fpc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic rdy);
        tick();
        apply(r, a, rdy);
    endtask

    task automatic release_reset(input logic rdy);
        tick();
        rst = 1'b1;
        model_reset();
        apply(1'b0, 32'h0, rdy);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check({tag, "_valid"}, out_valid, 32'd0);
        check({tag, "_pc"}, out_pc, 32'd0);
        check({tag, "_instr"}, out_instr, 32'd0);
        check({tag, "_pc4"}, out_pc_plus4, 32'd0);
        check({tag, "_fetch_pc"}, fetch_pc, RPC);
        check({tag, "_misalign"}, misalign_err, 32'd0);
        exp_status.delete();
        exp_txn.delete();
        repeat (2) @(posedge clk);
    endtask

    // Monitor: compare cycle status and every accepted transfer to the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (exp_status.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL status_underflow at %0t", $time);
            end else begin
                mon_s = exp_status.pop_front();
                check("out_valid", out_valid, mon_s.valid);
                if (mon_s.valid) begin
                    check("out_pc", out_pc, mon_s.pc);
                    check("out_instr", out_instr, rom_of(mon_s.pc));
                    check("out_pc_plus4", out_pc_plus4, mon_s.pc + 32'd4);
                end
                check("fetch_pc", fetch_pc, mon_s.fpc);
                check("misalign_err", misalign_err, mon_s.mis);
            end
            if (out_valid && out_ready && !redirect_en) begin
                if (exp_txn.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_transfer pc=%h at %0t", out_pc, $time);
                end else begin
                    mon_pc = exp_txn.pop_front();
                    check("transfer_pc", out_pc, mon_pc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r;
        logic [31:0] a;
        logic        rdy;

        // Reset state.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc4", out_pc_plus4, 32'd0);
        check("rst_fetch_pc", fetch_pc, RPC);
        check("rst_misalign", misalign_err, 32'd0);

        // Streaming from reset: valid in cycle 2, then one word per cycle.
        release_reset(1'b1);
        for (int i = 1; i < 14; i++) begin
            tick();
            check("a_valid", out_valid, (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) check("a_pc", out_pc, RPC + 32'(4 * (i - 2)));
            apply(1'b0, 32'h0, 1'b1);
        end

        // Mid-stream reset, then a 10-cycle stall from reset.
        pulse_reset("b");
        release_reset(1'b0);
        for (int i = 1; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        tick();
        check("c_fetch_pc", fetch_pc, RPC + 32'd16);
        check("c_valid", out_valid, 32'd1);
        apply(1'b0, 32'h0, 1'b1);
        for (int k = 1; k < 8; k++) begin
            tick();
            check("c_valid_gapless", out_valid, 32'd1);
            check("c_pc_order", out_pc, RPC + 32'(4 * k));
            apply(1'b0, 32'h0, 1'b1);
        end

        // Redirect with 3 queued entries and 1 read in flight.
        pulse_reset("d");
        release_reset(1'b0);
        for (int i = 1; i < 4; i++) step(1'b0, 32'h0, 1'b0);
        tick();
        check("d_fetch_pc_pre", fetch_pc, RPC + 32'd16);
        apply(1'b1, 32'h0000_0100, 1'b0);
        tick();
        check("d_valid_n1", out_valid, 32'd0);
        apply(1'b0, 32'h0, 1'b1);
        tick();
        check("d_valid_n2", out_valid, 32'd0);
        apply(1'b0, 32'h0, 1'b1);
        tick();
        check("d_valid_n3", out_valid, 32'd1);
        check("d_pc_n3", out_pc, 32'h0000_0100);
        apply(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

        // Redirect together with a pop of a valid head.
        tick();
        check("e_valid_head", out_valid, 32'd1);
        apply(1'b1, 32'h0000_0200, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1);
        tick();
        check("e_pc_target", out_pc, 32'h0000_0200);
        apply(1'b0, 32'h0, 1'b1);

        // Misaligned redirect: aligned target loaded, flag sticks.
        step(1'b1, 32'h0000_0102, 1'b1);
        tick();
        check("f_fetch_pc", fetch_pc, 32'h0000_0100);
        check("f_misalign", misalign_err, 32'd1);
        apply(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 32'h0, ($urandom_range(0, 1) == 1));
        tick();
        check("f_misalign_50", misalign_err, 32'd1);
        apply(1'b0, 32'h0, 1'b1);

        // ROM index wrap and 32-bit PC wrap.
        step(1'b1, 32'h0000_3FF8, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'hFFFF_FFF4, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic, including back-to-back redirects.
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 99) < 6);
            rdy = ($urandom_range(0, 99) < 70);
            case ($urandom_range(0, 3))
                0:       a = $urandom() & 32'h0000_FFFC;
                1:       a = 32'hFFFF_FFF0;
                2:       a = 32'h0000_3FF8;
                default: a = $urandom();
            endcase
            step(r, a, rdy);
        end

        // Reset clears the sticky flag; fetch restarts at RESET_PC with 2-cycle latency.
        pulse_reset("g");
        release_reset(1'b1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("g_valid", out_valid, (i >= 2) ? 32'd1 : 32'd0);
            if (i >= 2) check("g_pc", out_pc, RPC + 32'(4 * (i - 2)));
            apply(1'b0, 32'h0, 1'b1);
        end

        @(negedge clk);
        #1;
        if (exp_status.size() != 0 || exp_txn.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover status=%0d txn=%0d", exp_status.size(), exp_txn.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
